// File: rtl/dual_issue_router.sv
// dual_issue_router
//   Feeds the even/odd issue pipes. Takes one in-order instruction pair
//   per cycle, classifies each slot, and issues the pair in one cycle when
//   that is legal. Otherwise it splits the pair over two cycles and fills
//   the empty pipe with the pipe-specific no-op.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   fetch_valid/fetch_ready  pair handshake with fetch
//   fetch_instr0/1, fetch_pc older/younger instruction, PC of instr0
//   stall_in                 hold all issue state and outputs
//   flush                    squash the buffered pair and the outputs
//   instructionEven/Odd      registered pipe instructions
//   even_valid/odd_valid     slot carries a real instruction, not no-op fill
//   issue_pc                 PC of the oldest instruction issued
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | nothing buffered, ready to take a new pair
// ST_SECOND | younger half of a split pair waits to issue
module dual_issue_router #(
  parameter logic [0:31] EVEN_NOP = 32'h4020_0000,
  parameter logic [0:31] ODD_NOP  = 32'h0020_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [0:31] fetch_instr0,
  input  logic [0:31] fetch_instr1,
  input  logic [0:31] fetch_pc,
  input  logic        stall_in,
  input  logic        flush,
  output logic [0:31] instructionEven,
  output logic [0:31] instructionOdd,
  output logic        even_valid,
  output logic        odd_valid,
  output logic [0:31] issue_pc
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SECOND = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [0:31] buf_instr_q, buf_instr_d;
  logic [0:31] buf_pc_q, buf_pc_d;
  logic [0:31] even_q, even_d;
  logic [0:31] odd_q, odd_d;
  logic        even_valid_q, even_valid_d;
  logic        odd_valid_q, odd_valid_d;
  logic [0:31] issue_pc_q, issue_pc_d;

  logic accept;
  logic odd0, odd1, odd_buf;
  logic hazard;

  function automatic logic is_odd(input logic [0:31] instr);
    return (instr[0:3] == 4'b0011) || (instr[0:6] == 7'b0010000);
  endfunction

  always_comb begin
    odd0    = is_odd(fetch_instr0);
    odd1    = is_odd(fetch_instr1);
    odd_buf = is_odd(buf_instr_q);
    // Register-field compare ignores the actual format; a spurious match
    // only costs an extra split cycle.
    hazard  = (odd0 == odd1) ||
              (fetch_instr0[25:31] == fetch_instr1[18:24]) ||
              (fetch_instr0[25:31] == fetch_instr1[11:17]);

    fetch_ready = !reset && !stall_in && !flush && (state_q == ST_IDLE);
    accept      = fetch_valid && fetch_ready;

    state_d      = state_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    even_d       = even_q;
    odd_d        = odd_q;
    even_valid_d = even_valid_q;
    odd_valid_d  = odd_valid_q;
    issue_pc_d   = issue_pc_q;

    if (flush) begin
      state_d      = ST_IDLE;
      even_d       = EVEN_NOP;
      odd_d        = ODD_NOP;
      even_valid_d = 1'b0;
      odd_valid_d  = 1'b0;
    end else if (stall_in) begin
      // everything holds
    end else if (state_q == ST_SECOND) begin
      state_d      = ST_IDLE;
      even_d       = odd_buf ? EVEN_NOP : buf_instr_q;
      odd_d        = odd_buf ? buf_instr_q : ODD_NOP;
      even_valid_d = !odd_buf;
      odd_valid_d  = odd_buf;
      issue_pc_d   = buf_pc_q;
    end else if (accept) begin
      issue_pc_d = fetch_pc;
      if (hazard) begin
        state_d      = ST_SECOND;
        buf_instr_d  = fetch_instr1;
        buf_pc_d     = fetch_pc + 32'd4;
        even_d       = odd0 ? EVEN_NOP : fetch_instr0;
        odd_d        = odd0 ? fetch_instr0 : ODD_NOP;
        even_valid_d = !odd0;
        odd_valid_d  = odd0;
      end else begin
        // no hazard implies the slots use different pipes
        even_d       = odd0 ? fetch_instr1 : fetch_instr0;
        odd_d        = odd0 ? fetch_instr0 : fetch_instr1;
        even_valid_d = 1'b1;
        odd_valid_d  = 1'b1;
      end
    end else begin
      even_d       = EVEN_NOP;
      odd_d        = ODD_NOP;
      even_valid_d = 1'b0;
      odd_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      buf_instr_q  <= '0;
      buf_pc_q     <= '0;
      even_q       <= EVEN_NOP;
      odd_q        <= ODD_NOP;
      even_valid_q <= 1'b0;
      odd_valid_q  <= 1'b0;
      issue_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
      even_q       <= even_d;
      odd_q        <= odd_d;
      even_valid_q <= even_valid_d;
      odd_valid_q  <= odd_valid_d;
      issue_pc_q   <= issue_pc_d;
    end
  end

  assign instructionEven = even_q;
  assign instructionOdd  = odd_q;
  assign even_valid      = even_valid_q;
  assign odd_valid       = odd_valid_q;
  assign issue_pc        = issue_pc_q;

endmodule
